// File: rtl/cpu_pkg.sv
// Shared encodings for the execute stage: opcode/funct values, redirect
// select, and the multiply FSM state type. The multiply feature is built
// only when the MULDIV_EN macro is defined.
package cpu_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    // SPECIAL function codes (instr[5:0])
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    // Next-PC source select driven to fetch
    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_REG    = 2'd3
    } pc_src_e;

    // Multiply sequencer states
    typedef enum logic [1:0] {
        MUL_IDLE  = 2'd0,
        MUL_BUSY  = 2'd1,
        MUL_FIXUP = 2'd2
    } mul_state_e;

    // Field view of a 32-bit instruction word
    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instr_t;

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port. Register 0 is hardwired to zero on read and never written.
module regfile
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs_q [32];

    // Storage update: whole array cleared on reset, one word written per clock.
    // NOTE: this array is reset because every register must read 0 after reset;
    // that forces it into flops rather than a RAM macro, which is acceptable at 32x32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs_q[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs_q[raddr_b];

endmodule

// File: rtl/execute_stage.sv
// Single-cycle execute stage with registered writeback, WB->EX forwarding
// and redirect target generation. Defining MULDIV_EN adds a 33-cycle
// shift-add multiplier with HI/LO and MFHI/MFLO; otherwise those decode as NOP.
module execute_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction_EX,
    input  logic [9:0]  PC_FETCH,
    output logic [1:0]  pc_src_EX,
    output logic [9:0]  branch_addr_EX,
    output logic [9:0]  jtype_addr_EX,
    output logic [9:0]  reg_addr_EX,
    output logic        stall_EX,
    output logic        regwrite_WB,
    output logic [4:0]  regdest_WB,
    output logic [31:0] result_WB
);

    instr_t      ins;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] rf_rdata_a;
    logic [31:0] rf_rdata_b;
    logic [31:0] rs_val;
    logic [31:0] rt_val;

    pc_src_e     pc_src;
    logic        wr_en;
    logic [4:0]  wr_dst;
    logic [31:0] alu_res;

    logic        regwrite_d;
    logic [4:0]  regdest_d;
    logic [31:0] result_d;

    assign ins      = instr_t'(instruction_EX);
    assign imm_sext = {{16{instruction_EX[15]}}, instruction_EX[15:0]};
    assign imm_zext = {16'd0, instruction_EX[15:0]};

    regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (ins.rs),
        .raddr_b (ins.rt),
        .rdata_a (rf_rdata_a),
        .rdata_b (rf_rdata_b),
        .we      (regwrite_WB),
        .waddr   (regdest_WB),
        .wdata   (result_WB)
    );

    // The WB result lands in the array only at the next edge, so bypass it here.
    assign rs_val = (regwrite_WB && (regdest_WB == ins.rs) && (ins.rs != 5'd0)) ? result_WB : rf_rdata_a;
    assign rt_val = (regwrite_WB && (regdest_WB == ins.rt) && (ins.rt != 5'd0)) ? result_WB : rf_rdata_b;

    // Redirect targets are always computed; pc_src_EX decides whether fetch uses them.
    assign branch_addr_EX = PC_FETCH + instruction_EX[9:0];
    assign jtype_addr_EX  = instruction_EX[9:0];
    assign reg_addr_EX    = rs_val[9:0];
    assign pc_src_EX      = pc_src;

`ifdef MULDIV_EN
    mul_state_e  mul_state_q, mul_state_d;
    logic [4:0]  mul_cnt_q,   mul_cnt_d;
    logic [63:0] mcand_q,     mcand_d;
    logic [31:0] mplier_q,    mplier_d;
    logic [63:0] prod_q,      prod_d;
    logic        neg_q,       neg_d;
    logic [31:0] hi_q,        hi_d;
    logic [31:0] lo_q,        lo_d;
    logic        mul_start;
    logic        mul_signed;
    logic        is_mul_class;

    assign is_mul_class = (ins.opcode == OP_SPECIAL) &&
                          ((ins.funct == FN_MFHI) || (ins.funct == FN_MFLO) ||
                           (ins.funct == FN_MULT) || (ins.funct == FN_MULTU));
    assign stall_EX = is_mul_class && (mul_state_q != MUL_IDLE);
`else
    assign stall_EX = 1'b0;
`endif

    // Decode and execute the current instruction in one cycle.
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        pc_src  = PC_SEQ;
        wr_en   = 1'b0;
        wr_dst  = ins.rd;
        alu_res = '0;
`ifdef MULDIV_EN
        mul_start  = 1'b0;
        mul_signed = 1'b0;
`endif
        case (ins.opcode)
            OP_SPECIAL: begin
                case (ins.funct)
                    FN_SLL:  begin wr_en = 1'b1; alu_res = rt_val << ins.shamt; end
                    FN_SRL:  begin wr_en = 1'b1; alu_res = rt_val >> ins.shamt; end
                    FN_SRA:  begin wr_en = 1'b1; alu_res = $signed(rt_val) >>> ins.shamt; end
                    FN_ADDU: begin wr_en = 1'b1; alu_res = rs_val + rt_val; end
                    FN_SUBU: begin wr_en = 1'b1; alu_res = rs_val - rt_val; end
                    FN_AND:  begin wr_en = 1'b1; alu_res = rs_val & rt_val; end
                    FN_OR:   begin wr_en = 1'b1; alu_res = rs_val | rt_val; end
                    FN_XOR:  begin wr_en = 1'b1; alu_res = rs_val ^ rt_val; end
                    FN_NOR:  begin wr_en = 1'b1; alu_res = ~(rs_val | rt_val); end
                    FN_SLT:  begin wr_en = 1'b1; alu_res = {31'd0, $signed(rs_val) < $signed(rt_val)}; end
                    FN_SLTU: begin wr_en = 1'b1; alu_res = {31'd0, rs_val < rt_val}; end
                    FN_JR:   pc_src = PC_REG;
`ifdef MULDIV_EN
                    FN_MFHI:  begin wr_en = 1'b1; alu_res = hi_q; end
                    FN_MFLO:  begin wr_en = 1'b1; alu_res = lo_q; end
                    FN_MULT:  begin mul_start = 1'b1; mul_signed = 1'b1; end
                    FN_MULTU: mul_start = 1'b1;
`endif
                    default: ;
                endcase
            end
            OP_J:     pc_src = PC_JUMP;
            OP_BEQ:   if (rs_val == rt_val) pc_src = PC_BRANCH;
            OP_BNE:   if (rs_val != rt_val) pc_src = PC_BRANCH;
            OP_ADDIU: begin wr_en = 1'b1; wr_dst = ins.rt; alu_res = rs_val + imm_sext; end
            OP_SLTI:  begin wr_en = 1'b1; wr_dst = ins.rt; alu_res = {31'd0, $signed(rs_val) < $signed(imm_sext)}; end
            OP_ANDI:  begin wr_en = 1'b1; wr_dst = ins.rt; alu_res = rs_val & imm_zext; end
            OP_ORI:   begin wr_en = 1'b1; wr_dst = ins.rt; alu_res = rs_val | imm_zext; end
            OP_XORI:  begin wr_en = 1'b1; wr_dst = ins.rt; alu_res = rs_val ^ imm_zext; end
            OP_LUI:   begin wr_en = 1'b1; wr_dst = ins.rt; alu_res = {instruction_EX[15:0], 16'd0}; end
            default: ;
        endcase

        // A stalled instruction has no effect; it reissues once the multiplier is idle.
        if (stall_EX) begin
            pc_src = PC_SEQ;
            wr_en  = 1'b0;
`ifdef MULDIV_EN
            mul_start = 1'b0;
`endif
        end
        if (wr_dst == 5'd0) begin
            wr_en = 1'b0;
        end
    end

    assign regwrite_d = wr_en;
    assign regdest_d  = wr_en ? wr_dst  : 5'd0;
    assign result_d   = wr_en ? alu_res : 32'd0;

    // Writeback pipeline register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwrite_WB <= 1'b0;
            regdest_WB  <= '0;
            result_WB   <= '0;
        end else begin
            regwrite_WB <= regwrite_d;
            regdest_WB  <= regdest_d;
            result_WB   <= result_d;
        end
    end

`ifdef MULDIV_EN
    // Multiplier next-state: load magnitudes, 32 shift-add steps, then sign fix-up into HI/LO.
    always_comb begin
        mul_state_d = mul_state_q;
        mul_cnt_d   = mul_cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        prod_d      = prod_q;
        neg_d       = neg_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        case (mul_state_q)
            MUL_IDLE: begin
                if (mul_start) begin
                    mcand_d     = {32'd0, (mul_signed && rs_val[31]) ? -rs_val : rs_val};
                    mplier_d    = (mul_signed && rt_val[31]) ? -rt_val : rt_val;
                    prod_d      = '0;
                    neg_d       = mul_signed && (rs_val[31] ^ rt_val[31]);
                    mul_cnt_d   = 5'd0;
                    mul_state_d = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d   = mcand_q << 1;
                mplier_d  = mplier_q >> 1;
                mul_cnt_d = mul_cnt_q + 5'd1;
                if (mul_cnt_q == 5'd31) begin
                    mul_state_d = MUL_FIXUP;
                end
            end
            MUL_FIXUP: begin
                {hi_d, lo_d} = neg_q ? -prod_q : prod_q;
                mul_state_d  = MUL_IDLE;
            end
            default: mul_state_d = MUL_IDLE;
        endcase
    end

    // Multiplier state, datapath and HI/LO registers; reset aborts any operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_state_q <= MUL_IDLE;
            mul_cnt_q   <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            neg_q       <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            mul_state_q <= mul_state_d;
            mul_cnt_q   <= mul_cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            prod_q      <= prod_d;
            neg_q       <= neg_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end
`endif

endmodule
